// File: rtl/intra_edge_builder_pkg.sv
// Shared types and constants for the VP8 16x16 luma intra edge builder.
// Holds sample/row widths, the VP8 missing-edge substitutes, the FSM state
// enum and small lane helpers used by the top and the line buffer.
package intra_edge_builder_pkg;

    localparam int unsigned BIT_WIDTH  = 8;
    localparam int unsigned BLOCK_SIZE = 16;
    localparam int unsigned MAX_MB_W   = 64;
    localparam int unsigned MB_CNT_W   = 7;
    localparam int unsigned ROW_W      = BIT_WIDTH * BLOCK_SIZE;
    localparam int unsigned LB_ADDR_W  = $clog2(MAX_MB_W);
    localparam int unsigned LANE_IDX_W = $clog2(BLOCK_SIZE);
    // Index of the last lane in a row and of the last recon row in an MB
    localparam int unsigned LAST_IDX   = BLOCK_SIZE - 1;

    typedef logic [BIT_WIDTH-1:0] sample_t;
    typedef logic [ROW_W-1:0]     row_t;

    localparam sample_t VP8_TOP_DEFAULT  = 8'd127;
    localparam sample_t VP8_LEFT_DEFAULT = 8'd129;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

    // Extract sample 'idx' from a packed row (sample i at [i*BIT_WIDTH +: BIT_WIDTH])
    function automatic sample_t lane_sel(input row_t row, input logic [LANE_IDX_W-1:0] idx);
        return row[32'(idx)*BIT_WIDTH +: BIT_WIDTH];
    endfunction

    // Replicate one sample across every lane of a row
    function automatic row_t fill_row(input sample_t s);
        return {BLOCK_SIZE{s}};
    endfunction

endpackage

// File: rtl/intra_edge_linebuf.sv
// Line buffer holding the bottom recon row of each MB column (next MB row's top edge).
// Ports:
//   clk            clock (storage is not reset)
//   wr_en_i        write enable
//   wr_addr_i      MB column written
//   wr_data_i      row written
//   rd_addr_i      MB column read
//   rd_data_c      combinational read of rd_addr_i
//   wr_old_last_c  last lane of the entry at wr_addr_i, before any write this cycle
module intra_edge_linebuf
    import intra_edge_builder_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [LB_ADDR_W-1:0] wr_addr_i,
    input  row_t                 wr_data_i,
    input  logic [LB_ADDR_W-1:0] rd_addr_i,
    output row_t                 rd_data_c,
    output sample_t              wr_old_last_c
);

    row_t mem_q [MAX_MB_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c     = mem_q[rd_addr_i];
    assign wr_old_last_c = lane_sel(mem_q[wr_addr_i], LANE_IDX_W'(LAST_IDX));

endmodule

// File: rtl/intra_edge_builder.sv
// VP8 16x16 luma intra edge builder: walks MBs in raster order, offers each MB's
// top row / left column / top-left corner over a valid/ready handshake, then absorbs
// that MB's 16 recon rows to build the edges of the following MBs.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, mb_w, mb_h       frame start pulse and frame size in MBs (latched in IDLE)
//   busy, frame_done        frame in progress / one-cycle end-of-frame pulse
//   edge_valid, edge_ready  edge bundle handshake
//   top, left, top_left     edge bundle payload
//   edge_mb_x, edge_mb_y    position of the MB the bundle belongs to
//   rec_valid, rec_ready    recon row handshake
//   rec_row                 one recon row of the current MB, row 0 first
module intra_edge_builder
    import intra_edge_builder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MB_CNT_W-1:0]  mb_w,
    input  logic [MB_CNT_W-1:0]  mb_h,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 edge_valid,
    input  logic                 edge_ready,
    output logic [ROW_W-1:0]     top,
    output logic [ROW_W-1:0]     left,
    output logic [BIT_WIDTH-1:0] top_left,
    output logic [MB_CNT_W-1:0]  edge_mb_x,
    output logic [MB_CNT_W-1:0]  edge_mb_y,
    input  logic                 rec_valid,
    output logic                 rec_ready,
    input  logic [ROW_W-1:0]     rec_row
);

    state_e                state_q, state_d;
    logic [MB_CNT_W-1:0]   mb_w_q, mb_w_d, mb_h_q, mb_h_d;
    logic [MB_CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic [LANE_IDX_W-1:0] r_q, r_d;
    row_t                  left_q, left_d;
    sample_t               tl_q, tl_d;

    logic                  busy_q, frame_done_q, edge_valid_q, rec_ready_q;
    row_t                  top_q, top_d, left_out_q, left_out_d;
    sample_t               tl_out_q, tl_out_d;
    logic [MB_CNT_W-1:0]   mb_x_q, mb_y_q;

    logic                  edge_hs, rec_hs, last_col, last_row;
    logic                  lb_we;
    row_t                  lb_rd_data, top_src;
    sample_t               lb_old_last;

    assign edge_hs  = edge_valid_q & edge_ready;
    assign rec_hs   = rec_ready_q & rec_valid;
    assign last_col = (x_q == mb_w_q - 1'b1);
    assign last_row = (y_q == mb_h_q - 1'b1);

    intra_edge_linebuf u_linebuf (
        .clk           (clk),
        .wr_en_i       (lb_we),
        .wr_addr_i     (LB_ADDR_W'(x_q)),
        .wr_data_i     (rec_row),
        .rd_addr_i     (LB_ADDR_W'(x_d)),
        .rd_data_c     (lb_rd_data),
        .wr_old_last_c (lb_old_last)
    );

    // Next-state, MB walk and edge-register updates
    always_comb begin
        state_d = state_q;
        mb_w_d  = mb_w_q;
        mb_h_d  = mb_h_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        left_d  = left_q;
        tl_d    = tl_q;
        lb_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mb_w_d  = mb_w;
                    mb_h_d  = mb_h;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (edge_hs) begin
                    r_d     = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (rec_hs) begin
                    // Right column of this MB becomes the next MB's left edge
                    left_d[32'(r_q)*BIT_WIDTH +: BIT_WIDTH] = lane_sel(rec_row, LANE_IDX_W'(LAST_IDX));
                    r_d = r_q + 1'b1;
                    if (r_q == LANE_IDX_W'(LAST_IDX)) begin
                        // Corner for MB x+1 is the old bottom-right sample above this MB
                        lb_we = 1'b1;
                        tl_d  = lb_old_last;
                        if (last_col) begin
                            if (last_row) begin
                                state_d = DONE;
                            end else begin
                                x_d     = '0;
                                y_d     = y_q + 1'b1;
                                state_d = EMIT;
                            end
                        end else begin
                            x_d     = x_q + 1'b1;
                            state_d = EMIT;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Edge bundle for the MB about to be presented; with a one-MB-wide frame the
    // row being written this cycle is the next top edge, so forward it.
    always_comb begin
        top_src = (lb_we && (x_d == x_q)) ? rec_row : lb_rd_data;
        top_d      = (y_d == '0) ? fill_row(VP8_TOP_DEFAULT) : top_src;
        left_out_d = (x_d == '0) ? fill_row(VP8_LEFT_DEFAULT) : left_d;
        if (y_d == '0) begin
            tl_out_d = VP8_TOP_DEFAULT;
        end else if (x_d == '0) begin
            tl_out_d = VP8_LEFT_DEFAULT;
        end else begin
            tl_out_d = tl_d;
        end
    end

    // State and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mb_w_q  <= '0;
            mb_h_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            left_q  <= '0;
            tl_q    <= '0;
        end else begin
            state_q <= state_d;
            mb_w_q  <= mb_w_d;
            mb_h_q  <= mb_h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            left_q  <= left_d;
            tl_q    <= tl_d;
        end
    end

    // Registered outputs, decoded from the next state; bundle loads on entry to / while in EMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            edge_valid_q <= 1'b0;
            rec_ready_q  <= 1'b0;
            top_q        <= '0;
            left_out_q   <= '0;
            tl_out_q     <= '0;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
        end else begin
            busy_q       <= (state_d == EMIT) || (state_d == RECV);
            frame_done_q <= (state_d == DONE);
            edge_valid_q <= (state_d == EMIT);
            rec_ready_q  <= (state_d == RECV);
            if (state_d == EMIT) begin
                top_q      <= top_d;
                left_out_q <= left_out_d;
                tl_out_q   <= tl_out_d;
                mb_x_q     <= x_d;
                mb_y_q     <= y_d;
            end
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign edge_valid = edge_valid_q;
    assign rec_ready  = rec_ready_q;
    assign top        = top_q;
    assign left       = left_out_q;
    assign top_left   = tl_out_q;
    assign edge_mb_x  = mb_x_q;
    assign edge_mb_y  = mb_y_q;

endmodule

// File: tb/tb_intra_edge_builder.sv
// Testbench for intra_edge_builder: a picture-level model (every accepted recon
// row stored at its pixel position; edges read back from neighbouring pixels)
// checked every cycle, plus literal expectations for the directed frames.
module tb_intra_edge_builder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [6:0]   mb_w = 7'd1;
    logic [6:0]   mb_h = 7'd1;
    logic         busy, frame_done, edge_valid, rec_ready;
    logic         edge_ready = 1'b0;
    logic         rec_valid = 1'b0;
    logic [127:0] top, left, rec_row = '0;
    logic [7:0]   top_left;
    logic [6:0]   edge_mb_x, edge_mb_y;

    intra_edge_builder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mb_w       (mb_w),
        .mb_h       (mb_h),
        .busy       (busy),
        .frame_done (frame_done),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .top        (top),
        .left       (left),
        .top_left   (top_left),
        .edge_mb_x  (edge_mb_x),
        .edge_mb_y  (edge_mb_y),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_row    (rec_row)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = base + 8'(i);
        return v;
    endfunction

    // Recon row for MB (x,y), row r under directed pattern 'pat' (0 = random)
    function automatic logic [127:0] gen_row(input int pat, input int x, input int y, input int r);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'($urandom);
        case (pat)
            1: v = fill(8'h50);
            2: if (x == 0 && y == 0) v[127:120] = 8'(r + 1);
            3: if (x == 0 && y == 0 && r == 15) v = ramp(8'h00);
            4: begin
                if (x == 0 && y == 0 && r == 15) v[127:120] = 8'hAA;
                if (x == 1 && y == 0 && r == 15) v = fill(8'h33);
                if (x == 0 && y == 1) v[127:120] = 8'(8'h10 + r);
            end
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [7:0] pic [0:47][0:1023];
    int mode = 0;      // 0 idle, 1 frame running, 2 end-of-frame cycle
    int in_rows = 0;   // bundle of current MB accepted, rows being delivered
    int rcnt = 0, ex = 0, ey = 0, mw = 1, mh = 1;

    always @(negedge clk) begin : model_check
        logic [127:0] et, el;
        logic [7:0]   etl;
        if (!rst_n) begin
            chk("rst_ctrl", {busy, frame_done, edge_valid, rec_ready}, '0);
            chk("rst_top", top, '0);
            chk("rst_left", left, '0);
            chk("rst_misc", {top_left, edge_mb_x, edge_mb_y}, '0);
            mode = 0;
            in_rows = 0;
        end else begin
            chk("busy", busy, 128'(mode == 1));
            chk("frame_done", frame_done, 128'(mode == 2));
            chk("edge_valid", edge_valid, 128'(mode == 1 && in_rows == 0));
            chk("rec_ready", rec_ready, 128'(mode == 1 && in_rows == 1));
            if (mode == 1 && in_rows == 0) begin
                for (int i = 0; i < 16; i++) begin
                    if (ey == 0) et[i*8 +: 8] = 8'd127;
                    else         et[i*8 +: 8] = pic[ey*16-1][ex*16+i];
                    if (ex == 0) el[i*8 +: 8] = 8'd129;
                    else         el[i*8 +: 8] = pic[ey*16+i][ex*16-1];
                end
                if (ey == 0)      etl = 8'd127;
                else if (ex == 0) etl = 8'd129;
                else              etl = pic[ey*16-1][ex*16-1];
                chk("edge_pos", {edge_mb_x, edge_mb_y}, {7'(ex), 7'(ey)});
                chk("edge_top", top, et);
                chk("edge_left", left, el);
                chk("edge_top_left", top_left, etl);
            end
            if (mode == 2) begin
                mode = 0;
            end else if (mode == 0) begin
                if (start) begin
                    mode = 1; in_rows = 0; ex = 0; ey = 0;
                    mw = int'(mb_w); mh = int'(mb_h);
                end
            end else if (in_rows == 0) begin
                if (edge_ready) begin
                    in_rows = 1;
                    rcnt = 0;
                end
            end else if (rec_valid) begin
                for (int i = 0; i < 16; i++) pic[ey*16+rcnt][ex*16+i] = rec_row[i*8 +: 8];
                rcnt++;
                if (rcnt == 16) begin
                    in_rows = 0;
                    if (ex == mw - 1) begin
                        if (ey == mh - 1) mode = 2;
                        else begin ex = 0; ey++; end
                    end else begin
                        ex++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [127:0] cap_top [0:255];
    logic [127:0] cap_left [0:255];
    logic [7:0]   cap_tl [0:255];

    task automatic run_frame(input int w, input int h, input int pat, input bit stall,
                             input int abort_mb, output logic [1:0] done_flags, output int lat);
        int mb = 0, r = 0, cyc = 0, wcnt = 0, hs_cyc = 0;
        int n = w * h;
        bit ehs, rhs;
        done_flags = 2'b00;
        lat = 0;
        @(posedge clk); #1;
        mb_w = 7'(w); mb_h = 7'(h); start = 1'b1;
        edge_ready = !stall; rec_valid = 1'b1;
        rec_row = gen_row(pat, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (mb < n && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            ehs = edge_valid && edge_ready;
            rhs = rec_valid && rec_ready;
            if (ehs) begin
                cap_top[mb] = top; cap_left[mb] = left; cap_tl[mb] = top_left;
                hs_cyc = cyc;
            end
            if (edge_valid && !ehs) wcnt++;
            @(posedge clk); #1;
            if (ehs) wcnt = 0;
            if (rhs) begin
                r++;
                if (r == 16) begin r = 0; mb++; end
                rec_row = gen_row(pat, mb % w, mb / w, r);
            end
            if (stall) begin
                edge_ready = (wcnt >= 5);
                rec_valid = !rec_valid;
                // start while busy must be ignored, even with a different size
                start = (cyc == 10);
                if (cyc == 10) mb_w = 7'd5;
            end
            if (abort_mb >= 0 && mb == abort_mb && r == 7) break;
        end
        start = 1'b0;
        if (abort_mb < 0) begin
            if (mb < n) chk("frame_timeout", 128'(mb), 128'(n));
            @(negedge clk);
            cyc++;
            done_flags = {frame_done, busy};
            lat = cyc - hs_cyc;
            @(posedge clk); #1;
            rec_valid = 1'b0;
            edge_ready = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] df;
        int lat;
        repeat (3) @(negedge clk);
        chk("init_ctrl", {busy, frame_done, edge_valid, rec_ready}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1x1, flat rows: all substitutes, 17-cycle edge-to-done latency
        run_frame(1, 1, 1, 1'b0, -1, df, lat);
        chk("f11_top", cap_top[0], fill(8'd127));
        chk("f11_left", cap_left[0], fill(8'd129));
        chk("f11_tl", cap_tl[0], 8'd127);
        chk("f11_done_flags", df, 2'b10);
        chk("f11_latency", lat, 17);

        // 2x1: right column of MB0 becomes MB1 left
        run_frame(2, 1, 2, 1'b0, -1, df, lat);
        chk("f21_left", cap_left[1], ramp(8'd1));
        chk("f21_top", cap_top[1], fill(8'd127));
        chk("f21_tl", cap_tl[1], 8'd127);

        // 1x2: bottom row of MB0 becomes MB(0,1) top
        run_frame(1, 2, 3, 1'b0, -1, df, lat);
        chk("f12_top", cap_top[1], ramp(8'd0));
        chk("f12_left", cap_left[1], fill(8'd129));
        chk("f12_tl", cap_tl[1], 8'd129);

        // 2x2: interior MB(1,1) corner/top/left
        run_frame(2, 2, 4, 1'b0, -1, df, lat);
        chk("f22_tl", cap_tl[3], 8'hAA);
        chk("f22_top", cap_top[3], fill(8'h33));
        chk("f22_left", cap_left[3], ramp(8'h10));

        // 2x1 under backpressure: same bundle for MB1 as without stalls
        run_frame(2, 1, 2, 1'b1, -1, df, lat);
        chk("f21s_left", cap_left[1], ramp(8'd1));
        chk("f21s_top", cap_top[1], fill(8'd127));
        chk("f21s_done", df, 2'b10);

        // Random frames, random stall mode
        for (int k = 0; k < 6; k++) begin
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)), 0,
                      1'($urandom_range(0, 1)), -1, df, lat);
            chk("rand_done", df, 2'b10);
        end

        // Widest row: every line-buffer entry used
        run_frame(64, 2, 0, 1'b0, -1, df, lat);
        chk("wide_done", df, 2'b10);

        // Reset in the middle of RECV, then a clean 1x1 frame
        run_frame(3, 3, 0, 1'b0, 4, df, lat);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {busy, frame_done, edge_valid, rec_ready}, '0);
        chk("abort_top", top, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rec_valid = 1'b0;
        edge_ready = 1'b0;
        run_frame(1, 1, 0, 1'b0, -1, df, lat);
        chk("restart_top", cap_top[0], fill(8'd127));
        chk("restart_tl", cap_tl[0], 8'd127);
        chk("restart_left", cap_left[0], fill(8'd129));
        chk("restart_done", df, 2'b10);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intra_edge_builder.md
Name: intra_edge_builder

Overview:
- Upstream feeder for the 16x16 luma intra predictors (TM/DC/V/H) in the VP8 intra path.
- Walks macroblocks (MBs) in raster order. For each MB, presents the top row, the left column and the top-left sample through a valid/ready handshake.
- After each MB's edges are accepted, it absorbs that MB's 16 reconstructed rows. It keeps the bottom row in a line buffer (next MB row's top edge) and the right column in a register (next MB's left edge).
- Missing edges are substituted per VP8: top=127, left=129.

Parameters:
- BIT_WIDTH, 8, bits per sample
- BLOCK_SIZE, 16, MB edge length in samples
- MAX_MB_W, 64, maximum MBs per row (line-buffer depth)
- MB_CNT_W, 7, width of MB coordinate/count fields

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches mb_w/mb_h, begins frame; ignored unless IDLE
- mb_w  in  MB_CNT_W  MBs per row, 1..MAX_MB_W
- mb_h  in  MB_CNT_W  MB rows, >=1
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after last recon row of last MB
- edge_valid  out  1  edge bundle valid
- edge_ready  in  1  consumer accepts bundle
- top  out  BIT_WIDTH*BLOCK_SIZE  top edge; sample i at [i*BIT_WIDTH +: BIT_WIDTH]
- left  out  BIT_WIDTH*BLOCK_SIZE  left edge; sample j likewise
- top_left  out  BIT_WIDTH  corner sample
- edge_mb_x  out  MB_CNT_W  column of current MB
- edge_mb_y  out  MB_CNT_W  row of current MB
- rec_valid  in  1  recon row valid
- rec_ready  out  1  block accepts recon row
- rec_row  in  BIT_WIDTH*BLOCK_SIZE  one reconstructed row of current MB, row 0 first

Behaviour:
- Reset state: IDLE.
- Output values in reset: busy=0, frame_done=0, edge_valid=0, rec_ready=0, top/left/top_left/edge_mb_x/edge_mb_y=0.
- Line buffer contents are not reset. Left and corner registers reset to 0.
- FSM states: IDLE, EMIT, RECV, DONE.
- IDLE -> EMIT on start:
  - latch mb_w/mb_h;
  - x=y=0;
  - busy=1 from the next cycle.
- EMIT:
  - edge_valid=1; outputs held stable until edge_valid&&edge_ready.
  - On that handshake: go to RECV, row counter r=0.
  - Latency: edge_valid asserts the cycle after entry to EMIT.
- Edge values in EMIT:
  - top: 127 in every lane if y==0; else linebuf[x].
  - left: 129 in every lane if x==0; else left_reg.
  - top_left: 127 if y==0; else 129 if x==0; else tl_reg. The y==0 rule wins at (0,0).
- RECV:
  - rec_ready=1. Each rec_valid&&rec_ready writes left_reg lane r = rec_row lane 15, then r++.
  - On r==15 handshake, three updates happen in the same edge:
    - tl_reg <= old linebuf[x] lane 15, read before the write;
    - linebuf[x] <= rec_row;
    - advance MB position.
- MB advance:
  - x==mb_w-1 and y==mb_h-1 -> DONE.
  - x==mb_w-1 otherwise -> x=0, y++, EMIT.
  - else -> x++, EMIT.
- DONE: frame_done=1 for one cycle, busy=0, then IDLE.
- Handshake rules:
  - edge_valid and rec_ready are never high together.
  - No recon row is accepted before its MB's edges are accepted.
  - rec_valid while not in RECV is ignored (rec_ready=0). The producer holds data.
- Arithmetic and size rules:
  - Counters are unsigned and wrap-free.
  - mb_w=0 or mb_w>MAX_MB_W gives undefined results; the bench must not drive these.
- Reset mid-frame: rst_n low aborts immediately to IDLE with all outputs at reset values. The next start begins a clean frame (y==0 substitutes, so stale linebuf is never read).
- start while busy: ignored.
- Throughput: 1 cycle EMIT + 16 cycles RECV per MB with zero stalls (17 cycles/MB). The DONE cycle adds 1 per frame.

Decomposition:
- Shared package holds:
  - VP8_TOP_DEFAULT=8'd127 and VP8_LEFT_DEFAULT=8'd129;
  - state enum (IDLE/EMIT/RECV/DONE);
  - lane-select helper function.
- One sub-module: intra_edge_linebuf.
  - MAX_MB_W x (BIT_WIDTH*BLOCK_SIZE) storage.
  - Synchronous write; combinational read of the addressed entry.
  - Extra output of lane 15 of the written address, pre-write.

Test Plan:
- 1x1 frame, rows all 0x50 -> edge top=all 127, left=all 129, top_left=127. After 16 rows: frame_done pulse, busy falls, 17 cycles after the edge handshake at zero stall.
- 2x1 frame, MB0 row r lane15 = r+1 -> MB1 left lane j = j+1, top=all 127, top_left=127.
- 1x2 frame, MB0 row15 lanes = 0..15 -> MB(0,1) top lanes = 0..15, left=all 129, top_left=129.
- 2x2 frame, MB0 row15 lane15=0xAA, MB1 row15=0x33s -> MB(1,1) top_left=0xAA, top=all 0x33, left = MB(0,1) column 15.
- Backpressure: edge_ready low 5 cycles, rec_valid toggled every other cycle -> edge outputs stable while stalled, rec_ready=0 during EMIT, the same 16 rows are captured, and the bundle for the following MB is unchanged versus the no-stall run.
- rst_n pulsed low mid-RECV in 3x3 frame, then restart with 1x1 frame -> all outputs 0 during reset. The restarted MB shows y==0 substitutes (top 127, top_left 127) and no stale data.
